tempo_gen: RTL
==============

# tempo_gen

Programmable tempo generator: divides `clk` into a tick stream, groups ticks into beats and beats into bars, and emits single-cycle `tick`, `beat` and `downbeat` strobes with position indices. It is the parametrised successor of the fixed 4 Hz beat strobe. It feeds the note sequencer and the metronome/LED logic. Tempo, subdivision and meter can all change at runtime without glitches.

## Interface
- `CNT_W`, 25, width of the tick-period counter and `period_in`
- `DEF_PERIOD`, 12_500_000, tick period in clk cycles after reset (4 Hz at 50 MHz)
- `SUB_W`, 3, width of `sub_div` and `tick_idx`
- `BAR_W`, 3, width of `beats_per_bar` and `beat_idx`
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `en`  in  1  run enable; low freezes all counters
- `clr`  in  1  synchronous restart: counters to 0, pending period applied
- `period_in`  in  CNT_W  requested tick period in cycles
- `period_load`  in  1  one-cycle strobe that captures `period_in` as pending period
- `sub_div`  in  SUB_W  ticks per beat; 0 is treated as 1
- `beats_per_bar`  in  BAR_W  beats per bar; 0 is treated as 1
- `tick`  out  1  one-cycle strobe per tick
- `beat`  out  1  one-cycle strobe, coincident with `tick`, on tick index 0
- `downbeat`  out  1  one-cycle strobe, coincident with `beat`, on beat index 0
- `tick_idx`  out  SUB_W  index of the current tick within its beat; updated with `tick`
- `beat_idx`  out  BAR_W  index of the current beat within its bar; updated with `tick`

## Operation
- Reset values: `cnt`=0, `nt`=0, `nb`=0, `period`=`DEF_PERIOD`, `pend`=`DEF_PERIOD`. All outputs are 0.
- Effective period is max(`period`, 2). Values 0 and 1 are clamped to 2.
- `period_load` writes `pend` only. `period` <= `pend` at a wrap cycle, at a `clr` cycle, and on any cycle with `en`=0.
  - The interval in progress is never shortened or stretched.
  - `period_load` on the same cycle as a wrap: the old `pend` goes to `period` and the new value goes to `pend`, so it is applied at the following wrap.
- With `en`=1: `cnt` increments each cycle. At `cnt`==period-1 (the wrap cycle) `cnt`<=0 and a tick event fires.
- Tick event, all registered on the same edge:
  - `tick`<=1, `tick_idx`<=`nt`, `beat_idx`<=`nb`
  - `beat`<=(`nt`==0), `downbeat`<=(`nt`==0 && `nb`==0)
- Advance after a tick event:
  - `nt`<=(`nt`+1 >= sub_eff) ? 0 : `nt`+1.
  - When `nt` wraps: `nb`<=(`nb`+1 >= bpb_eff) ? 0 : `nb`+1.
  - The `>=` compare makes a reduced `sub_div` or `beats_per_bar` wrap at once instead of running past the limit.
- `sub_div` and `beats_per_bar` are sampled live at each tick event. There is no extra staging.
- `en`=0: `cnt`, `nt` and `nb` hold. Strobes are 0. Indices hold their last value. Resuming continues the partial interval.
- `clr` has priority over `en`. It sets `cnt`, `nt`, `nb`, `tick_idx` and `beat_idx` to 0 and all strobes to 0. The next tick is therefore a downbeat.
- Reset mid-interval: all state returns to reset values immediately (asynchronous). No strobe is produced.

## Timing
- Strobes are registered and 1 cycle wide. They are asserted on the edge after the wrap cycle.
- From reset release or `clr` with `en`=1, the first `tick` occurs on the P-th rising edge (P = effective period). Later ticks repeat every P cycles.
- The first tick after reset or `clr` is always `beat`=`downbeat`=1 with both indices 0.
- Minimum tick spacing is 2 cycles, so strobes are never high on back-to-back cycles.
- Latency of a period change is at most one old interval plus one new interval.

## Structure
- Shared package `tempo_pkg` holds:
  - `CLK_HZ`=50_000_000
  - `DEF_PERIOD`
  - `MIN_PERIOD`=2
  - the helper function `eff1(x)`, which maps 0 to 1
- One sub-module is natural: `tick_divider`. It contains `cnt`, `period`/`pend` staging and wrap detection, and outputs a `wrap` pulse.
- `tempo_gen` contains the `nt`/`nb` position counters and the output registers.

## Test plan
- Reset defaults: hold `rst` 3 cycles, release with `en`=1 and `DEF_PERIOD` overridden to 4, sub=2, bpb=3. Required response:
  - `tick` on edges 4, 8, 12, …
  - `beat` on edges 4, 12, 20
  - `downbeat` on edges 4 and 28
  - `tick_idx` sequence 0,1,0,1; `beat_idx` sequence 0,0,1,1,2,2,0
- Period change: with period 10 running, pulse `period_load` with 4 at `cnt`=3. Required response: the current interval still ends at 10 cycles, then ticks follow every 4 cycles.
- Clamp: load period 0 while `en`=0, then set `en`=1. Required response: ticks every 2 cycles, never on consecutive cycles.
- Meter shrink: bpb=4, and at `beat_idx`=2 set bpb=2. Required response: the next beat is `beat_idx`=0 with `downbeat`=1.
- Pause/resume: period 8, drop `en` for 5 cycles at `cnt`=5. Required response: the next tick comes 3 enabled cycles after resume, and all strobes are 0 during the pause.
- Clear and async reset: assert `clr` mid-bar. Required response: the next tick arrives after a full period with `downbeat`=1. Assert `rst` mid-cycle. Required response: outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/tempo_pkg.sv
// rtl/tempo_pkg.sv - shared constants and helpers for the tempo generator
package tempo_pkg;

    localparam int unsigned CLK_HZ     = 50_000_000;
    localparam int unsigned DEF_PERIOD = 12_500_000;
    localparam int unsigned MIN_PERIOD = 2;

    // Wide enough to hold any sub_div/beats_per_bar value plus one without overflow.
    localparam int EFF_W = 16;
    typedef logic [EFF_W-1:0] eff_t;

    function automatic eff_t eff1(input eff_t x);
        return (x == '0) ? eff_t'(1) : x;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - tick period counter with glitch-free period staging
import tempo_pkg::*;

module tick_divider #(
    parameter int          CNT_W      = 25,
    parameter int unsigned DEF_PERIOD = tempo_pkg::DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period_in,
    input  logic             period_load,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] period_eff;

    assign period_eff = (period < MIN_P) ? MIN_P : period;

    // >= rather than == so a count left above a smaller period wraps instead of running away.
    assign wrap = en && !clr && (cnt >= (period_eff - ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            period <= DEF_P;
            pend   <= DEF_P;
        end else begin
            if (period_load) begin
                pend <= period_in;
            end
            if (clr) begin
                cnt    <= '0;
                period <= pend;
            end else if (en) begin
                if (wrap) begin
                    cnt    <= '0;
                    period <= pend;
                end else begin
                    cnt <= cnt + ONE;
                end
            end else begin
                period <= pend;
            end
        end
    end

endmodule

// File: rtl/tempo_gen.sv
// rtl/tempo_gen.sv - programmable tick/beat/bar strobe generator
import tempo_pkg::*;

module tempo_gen #(
    parameter int          CNT_W      = 25,
    parameter int unsigned DEF_PERIOD = tempo_pkg::DEF_PERIOD,
    parameter int          SUB_W      = 3,
    parameter int          BAR_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period_in,
    input  logic             period_load,
    input  logic [SUB_W-1:0] sub_div,
    input  logic [BAR_W-1:0] beats_per_bar,
    output logic             tick,
    output logic             beat,
    output logic             downbeat,
    output logic [SUB_W-1:0] tick_idx,
    output logic [BAR_W-1:0] beat_idx
);

    logic             wrap;
    logic [SUB_W-1:0] nt;
    logic [BAR_W-1:0] nb;
    eff_t             sub_eff;
    eff_t             bpb_eff;
    eff_t             nt_inc;
    eff_t             nb_inc;

    tick_divider #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clr         (clr),
        .period_in   (period_in),
        .period_load (period_load),
        .wrap        (wrap)
    );

    // Meter inputs are sampled live; the >= compare wraps at once when the limit shrinks.
    assign sub_eff = eff1(eff_t'(sub_div));
    assign bpb_eff = eff1(eff_t'(beats_per_bar));
    assign nt_inc  = eff_t'(nt) + eff_t'(1);
    assign nb_inc  = eff_t'(nb) + eff_t'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nt       <= '0;
            nb       <= '0;
            tick     <= 1'b0;
            beat     <= 1'b0;
            downbeat <= 1'b0;
            tick_idx <= '0;
            beat_idx <= '0;
        end else if (clr) begin
            nt       <= '0;
            nb       <= '0;
            tick     <= 1'b0;
            beat     <= 1'b0;
            downbeat <= 1'b0;
            tick_idx <= '0;
            beat_idx <= '0;
        end else begin
            tick     <= 1'b0;
            beat     <= 1'b0;
            downbeat <= 1'b0;
            if (wrap) begin
                tick     <= 1'b1;
                tick_idx <= nt;
                beat_idx <= nb;
                beat     <= (nt == '0);
                downbeat <= (nt == '0) && (nb == '0);
                if (nt_inc >= sub_eff) begin
                    nt <= '0;
                    if (nb_inc >= bpb_eff) begin
                        nb <= '0;
                    end else begin
                        nb <= nb_inc[BAR_W-1:0];
                    end
                end else begin
                    nt <= nt_inc[SUB_W-1:0];
                end
            end
        end
    end

endmodule
